pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the single-cycle/pipelined CPU datapath; it replaces the fixed 32-bit, reset-to-zero PC register. It holds the fetch address, advances it by a configurable step when fetch accepts it, and takes prioritised redirects (trap, branch/jump). It checks redirect-target alignment, records the faulting address, and supports halt/resume through a small control FSM. It sits between the next-PC logic and instruction memory.

## Interface
- `WIDTH`, 32: PC width in bits.
- `RESET_VECTOR`, 32'h0000_0000: PC value loaded by reset.
- `TRAP_VECTOR`, 32'h0000_0080: PC value loaded on a trap or misaligned redirect.
- `STEP`, 4: sequential increment. Must be a power of two.
- `ALIGN_BITS`, 2: number of low target bits that must be zero.

- `clk`, in, 1: clock. All state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `fetch_ready`, in, 1: instruction memory accepts `pc` this cycle.
- `redirect_valid`, in, 1: branch/jump taken.
- `redirect_target`, in, WIDTH: branch/jump destination.
- `trap`, in, 1: external exception request.
- `halt`, in, 1: stop issuing fetches.
- `resume`, in, 1: leave HALT.
- `pc`, out, WIDTH: current fetch address (registered).
- `pc_valid`, out, 1: `pc` is a valid fetch request.
- `pc_seq`, out, WIDTH: `pc + STEP`, combinational, wraps modulo 2^WIDTH.
- `misalign`, out, 1: one-cycle pulse; a misaligned redirect was rejected.
- `bad_addr`, out, WIDTH: last rejected redirect target (sticky).
- `halted`, out, 1: FSM is in HALT.

## Operation
- FSM states: BOOT, RUN, HALT.
  - BOOT: entered on reset. `pc_valid` = 0. Moves to RUN after exactly 1 cycle.
  - RUN: `pc_valid` = 1.
  - HALT: `pc_valid` = 0 and `pc` is frozen. `resume` moves the FSM to RUN.
- Next-PC priority in RUN, highest first:
  1. `trap`: `pc` <= TRAP_VECTOR.
  2. `redirect_valid` with any of `redirect_target[ALIGN_BITS-1:0]` nonzero: `pc` <= TRAP_VECTOR, `misalign` pulses, `bad_addr` <= target.
  3. `redirect_valid`, aligned target: `pc` <= `redirect_target`.
  4. `fetch_ready`: `pc` <= `pc_seq`.
  5. Otherwise: hold (stall).
- Trap and redirect are taken even when `fetch_ready` = 0. The current request is abandoned.
- `halt` in RUN: FSM goes to HALT next cycle. The next-PC update for that same cycle still applies, so a simultaneous redirect is not lost.
- In HALT, `trap` and `redirect_valid` still update `pc` (same priority as RUN), so a debug redirect is possible. Sequential increment is suppressed.
- `halt` and `resume` together in HALT: stay in HALT. `resume` in RUN or BOOT: ignored.
- Arithmetic: `pc_seq` is truncated to WIDTH bits, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset values: `pc` = RESET_VECTOR, `pc_valid` = 0, `misalign` = 0, `bad_addr` = 0, `halted` = 0, state = BOOT.
- `reset` has priority over every other input on the same edge, including mid-stall and in HALT.
- Latency: redirect, trap or increment is visible on `pc` one cycle after the input is sampled.
- `pc_valid` rises 1 cycle after reset is deasserted.
- `halted` rises the cycle after `halt` is sampled.
- `misalign` is high for exactly one cycle: the cycle in which `pc` = TRAP_VECTOR appears.
- Handshake: `pc` is stable while `pc_valid` = 1 and `fetch_ready` = 0, unless a trap or redirect occurs.

## Structure
- Package `pc_pkg`:
  - state enum `pc_state_t` {BOOT, RUN, HALT};
  - next-PC select enum `pc_sel_t` {SEL_TRAP, SEL_MISALIGN, SEL_REDIRECT, SEL_SEQ, SEL_HOLD};
  - default vector constants.
- Sub-module `pc_next_sel`: combinational priority encoder producing `pc_sel_t` and the misalign flag.
- Top-level `pc_unit`: FSM, PC register, `bad_addr` register, adder.

## Test plan
- Reset with RESET_VECTOR = 32'h0000_1000, `fetch_ready` = 1 → `pc_valid` low for 1 cycle, then `pc` = 1000, 1004, 1008 on consecutive cycles.
- `fetch_ready` low for 3 cycles at `pc` = 32'h1008 → `pc` holds at 1008 with `pc_valid` = 1, then advances to 100C.
- Same cycle: `redirect_valid` = 1, target 32'h2000, `trap` = 1 → `pc` = 32'h80. Next cycle, redirect alone to 32'h2000 → `pc` = 2000.
- Redirect to 32'h2002 → `pc` = 32'h80, `misalign` pulses for 1 cycle, `bad_addr` = 2002.
- `halt` with a simultaneous redirect to 32'h3000 → `pc` = 3000 and `halted` = 1 next cycle, then `pc` frozen for 5 cycles. `resume` → increments resume at 3004.
- `pc` = 32'hFFFF_FFFC with `fetch_ready` = 1 → `pc` wraps to 0. Reset asserted while in HALT → `pc` = RESET_VECTOR, FSM in BOOT.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program-counter unit.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    typedef enum logic [2:0] {
        SEL_TRAP     = 3'd0,
        SEL_MISALIGN = 3'd1,
        SEL_REDIRECT = 3'd2,
        SEL_SEQ      = 3'd3,
        SEL_HOLD     = 3'd4
    } pc_sel_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0080;
    localparam int unsigned DEFAULT_STEP         = 4;
    localparam int unsigned DEFAULT_ALIGN_BITS   = 2;

endpackage

// File: rtl/pc_if.sv
// Fetch-side bundle between next-PC logic, instruction memory and the PC unit.
interface pc_if #(
    parameter int unsigned WIDTH = 32
);
    logic             fetch_ready;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             trap;
    logic             halt;
    logic             resume;
    logic [WIDTH-1:0] pc;
    logic             pc_valid;
    logic [WIDTH-1:0] pc_seq;
    logic             misalign;
    logic [WIDTH-1:0] bad_addr;
    logic             halted;

    modport master (
        output fetch_ready, redirect_valid, redirect_target, trap, halt, resume,
        input  pc, pc_valid, pc_seq, misalign, bad_addr, halted
    );

    modport slave (
        input  fetch_ready, redirect_valid, redirect_target, trap, halt, resume,
        output pc, pc_valid, pc_seq, misalign, bad_addr, halted
    );
endinterface

// File: rtl/pc_next_sel.sv
// Next-PC priority encoder: trap > misaligned redirect > redirect > sequential > hold.
// Purely combinational, zero latency.
// Sequential advance only when seq_en and fetch_ready; redirects ignore fetch_ready.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ALIGN_BITS = DEFAULT_ALIGN_BITS
) (
    input  logic             redir_en_i,
    input  logic             seq_en_i,
    input  logic             trap_i,
    input  logic             redirect_valid_i,
    input  logic [WIDTH-1:0] redirect_target_i,
    input  logic             fetch_ready_i,
    output pc_sel_t          sel_o,
    output logic             misalign_o
);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    logic target_bad;
    assign target_bad = |(redirect_target_i & ALIGN_MASK);

    always_comb begin
        sel_o      = SEL_HOLD;
        misalign_o = 1'b0;
        if (redir_en_i && trap_i) begin
            sel_o = SEL_TRAP;
        end else if (redir_en_i && redirect_valid_i && target_bad) begin
            sel_o      = SEL_MISALIGN;
            misalign_o = 1'b1;
        end else if (redir_en_i && redirect_valid_i) begin
            sel_o = SEL_REDIRECT;
        end else if (seq_en_i && fetch_ready_i) begin
            sel_o = SEL_SEQ;
        end
    end
endmodule

// File: rtl/pc_unit.sv
// Program counter with boot/run/halt control, prioritised redirects and alignment check.
// PC, misalign and halted update one cycle after inputs are sampled; pc_seq is combinational.
// PC holds while fetch_ready is low unless a trap or redirect arrives.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(DEFAULT_TRAP_VECTOR),
    parameter int unsigned      STEP         = DEFAULT_STEP,
    parameter int unsigned      ALIGN_BITS   = DEFAULT_ALIGN_BITS
) (
    input  logic clk,
    input  logic reset,
    pc_if.slave  bus
);
    pc_state_t        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] bad_addr_q, bad_addr_d;
    logic             misalign_q;
    logic [WIDTH-1:0] pc_seq;
    pc_sel_t          sel;
    logic             misalign_d;

    assign pc_seq = pc_q + WIDTH'(STEP);

    // BOOT ignores everything; HALT still honours trap/redirect for debug.
    pc_next_sel #(
        .WIDTH      (WIDTH),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_next_sel (
        .redir_en_i        (state_q != BOOT),
        .seq_en_i          (state_q == RUN),
        .trap_i            (bus.trap),
        .redirect_valid_i  (bus.redirect_valid),
        .redirect_target_i (bus.redirect_target),
        .fetch_ready_i     (bus.fetch_ready),
        .sel_o             (sel),
        .misalign_o        (misalign_d)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        bad_addr_d = bad_addr_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (bus.halt) state_d = HALT;
            HALT:    if (bus.resume && !bus.halt) state_d = RUN;
            default: state_d = BOOT;
        endcase
        case (sel)
            SEL_TRAP:     pc_d = TRAP_VECTOR;
            SEL_MISALIGN: begin
                pc_d       = TRAP_VECTOR;
                bad_addr_d = bus.redirect_target;
            end
            SEL_REDIRECT: pc_d = bus.redirect_target;
            SEL_SEQ:      pc_d = pc_seq;
            default:      pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            bad_addr_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            bad_addr_q <= bad_addr_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_valid = (state_q == RUN);
    assign bus.pc_seq   = pc_seq;
    assign bus.misalign = misalign_q;
    assign bus.bad_addr = bad_addr_q;
    assign bus.halted   = (state_q == HALT);
endmodule

// File: tb/tb_pc_unit.sv
// Directed test of pc_unit with a non-zero reset vector.
module tb_pc_unit;
    localparam logic [31:0] RV = 32'h0000_1000;
    localparam logic [31:0] TV = 32'h0000_0080;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pc_if #(.WIDTH(32)) bus ();

    pc_unit #(
        .WIDTH        (32),
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV),
        .STEP         (4),
        .ALIGN_BITS   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.fetch_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = '0;
        bus.trap = 1'b0;
        bus.halt = 1'b0;
        bus.resume = 1'b0;
        step();
        step();
        reset = 1'b0;
        checks += 5;
        if (bus.pc !== RV) begin errors++; $display("FAIL reset_pc got %h exp %h", bus.pc, RV); end
        if (bus.pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.pc_valid); end
        if (bus.misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", bus.misalign); end
        if (bus.bad_addr !== 32'h0) begin errors++; $display("FAIL reset_bad_addr got %h exp 0", bus.bad_addr); end
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", bus.halted); end
        step();
        checks += 2;
        if (bus.pc_valid !== 1'b1) begin errors++; $display("FAIL boot_valid got %b exp 1", bus.pc_valid); end
        if (bus.pc !== 32'h1000) begin errors++; $display("FAIL boot_pc got %h exp 1000", bus.pc); end
        step();
        checks++;
        if (bus.pc !== 32'h1004) begin errors++; $display("FAIL seq1 got %h exp 1004", bus.pc); end
        step();
        checks += 2;
        if (bus.pc !== 32'h1008) begin errors++; $display("FAIL seq2 got %h exp 1008", bus.pc); end
        if (bus.pc_seq !== 32'h100C) begin errors++; $display("FAIL pc_seq got %h exp 100c", bus.pc_seq); end
    endtask

    task automatic test_stall();
        bus.fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks += 2;
            if (bus.pc !== 32'h1008) begin errors++; $display("FAIL stall_pc[%0d] got %h exp 1008", i, bus.pc); end
            if (bus.pc_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", i, bus.pc_valid); end
        end
        bus.fetch_ready = 1'b1;
        step();
        checks++;
        if (bus.pc !== 32'h100C) begin errors++; $display("FAIL stall_release got %h exp 100c", bus.pc); end
    endtask

    task automatic test_priority();
        bus.fetch_ready = 1'b0;
        bus.trap = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h2000;
        step();
        checks += 2;
        if (bus.pc !== TV) begin errors++; $display("FAIL trap_over_redirect got %h exp 80", bus.pc); end
        if (bus.misalign !== 1'b0) begin errors++; $display("FAIL trap_misalign got %b exp 0", bus.misalign); end
        bus.trap = 1'b0;
        step();
        checks++;
        if (bus.pc !== 32'h2000) begin errors++; $display("FAIL redirect got %h exp 2000", bus.pc); end
        bus.redirect_valid = 1'b0;
        bus.fetch_ready = 1'b1;
        step();
        checks++;
        if (bus.pc !== 32'h2004) begin errors++; $display("FAIL after_redirect got %h exp 2004", bus.pc); end
    endtask

    task automatic test_misalign();
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h2002;
        step();
        checks += 3;
        if (bus.pc !== TV) begin errors++; $display("FAIL misalign_pc got %h exp 80", bus.pc); end
        if (bus.misalign !== 1'b1) begin errors++; $display("FAIL misalign_pulse got %b exp 1", bus.misalign); end
        if (bus.bad_addr !== 32'h2002) begin errors++; $display("FAIL bad_addr got %h exp 2002", bus.bad_addr); end
        bus.redirect_valid = 1'b0;
        step();
        checks += 3;
        if (bus.misalign !== 1'b0) begin errors++; $display("FAIL misalign_clear got %b exp 0", bus.misalign); end
        if (bus.bad_addr !== 32'h2002) begin errors++; $display("FAIL bad_addr_sticky got %h exp 2002", bus.bad_addr); end
        if (bus.pc !== 32'h84) begin errors++; $display("FAIL post_misalign_pc got %h exp 84", bus.pc); end
    endtask

    task automatic test_halt();
        bus.halt = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h3000;
        step();
        checks += 3;
        if (bus.pc !== 32'h3000) begin errors++; $display("FAIL halt_redirect got %h exp 3000", bus.pc); end
        if (bus.halted !== 1'b1) begin errors++; $display("FAIL halted got %b exp 1", bus.halted); end
        if (bus.pc_valid !== 1'b0) begin errors++; $display("FAIL halt_valid got %b exp 0", bus.pc_valid); end
        bus.halt = 1'b0;
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks += 2;
            if (bus.pc !== 32'h3000) begin errors++; $display("FAIL halt_frozen[%0d] got %h exp 3000", i, bus.pc); end
            if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_stay[%0d] got %b exp 1", i, bus.halted); end
        end
        bus.resume = 1'b1;
        step();
        checks += 3;
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL resume_halted got %b exp 0", bus.halted); end
        if (bus.pc_valid !== 1'b1) begin errors++; $display("FAIL resume_valid got %b exp 1", bus.pc_valid); end
        if (bus.pc !== 32'h3000) begin errors++; $display("FAIL resume_pc got %h exp 3000", bus.pc); end
        bus.resume = 1'b0;
        step();
        checks++;
        if (bus.pc !== 32'h3004) begin errors++; $display("FAIL resume_inc got %h exp 3004", bus.pc); end
    endtask

    task automatic test_halt_debug();
        bus.halt = 1'b1;
        step();
        bus.halt = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h4000;
        step();
        checks += 2;
        if (bus.pc !== 32'h4000) begin errors++; $display("FAIL debug_redirect got %h exp 4000", bus.pc); end
        if (bus.halted !== 1'b1) begin errors++; $display("FAIL debug_halted got %b exp 1", bus.halted); end
        bus.redirect_valid = 1'b0;
        bus.halt = 1'b1;
        bus.resume = 1'b1;
        step();
        checks += 2;
        if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_and_resume got %b exp 1", bus.halted); end
        if (bus.pc !== 32'h4000) begin errors++; $display("FAIL halt_and_resume_pc got %h exp 4000", bus.pc); end
        bus.halt = 1'b0;
        step();
        bus.resume = 1'b0;
        checks++;
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL debug_resume got %b exp 0", bus.halted); end
    endtask

    task automatic test_wrap();
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        checks += 2;
        if (bus.pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got %h exp fffffffc", bus.pc); end
        if (bus.pc_seq !== 32'h0) begin errors++; $display("FAIL wrap_seq got %h exp 0", bus.pc_seq); end
        step();
        checks++;
        if (bus.pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", bus.pc); end
        bus.resume = 1'b1;
        step();
        bus.resume = 1'b0;
        checks += 2;
        if (bus.pc !== 32'h4) begin errors++; $display("FAIL resume_in_run_pc got %h exp 4", bus.pc); end
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL resume_in_run got %b exp 0", bus.halted); end
    endtask

    task automatic test_reset_in_halt();
        bus.halt = 1'b1;
        step();
        bus.halt = 1'b0;
        checks++;
        if (bus.halted !== 1'b1) begin errors++; $display("FAIL pre_reset_halt got %b exp 1", bus.halted); end
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h5000;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.redirect_valid = 1'b0;
        checks += 4;
        if (bus.pc !== RV) begin errors++; $display("FAIL halt_reset_pc got %h exp 1000", bus.pc); end
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_reset_halted got %b exp 0", bus.halted); end
        if (bus.pc_valid !== 1'b0) begin errors++; $display("FAIL halt_reset_valid got %b exp 0", bus.pc_valid); end
        if (bus.bad_addr !== 32'h0) begin errors++; $display("FAIL halt_reset_bad got %h exp 0", bus.bad_addr); end
        step();
        checks += 2;
        if (bus.pc_valid !== 1'b1) begin errors++; $display("FAIL reboot_valid got %b exp 1", bus.pc_valid); end
        if (bus.pc !== RV) begin errors++; $display("FAIL reboot_pc got %h exp 1000", bus.pc); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stall();
        test_priority();
        test_misalign();
        test_halt();
        test_halt_debug();
        test_wrap();
        test_reset_in_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
